// File: rtl/rsa_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// rsa_ctrl_pkg
// Shared definitions for the RSA command/DMA sequencer:
//   - state_e      : sequencer states, encoded with the 4-bit code that is
//                    reported in status[11:8]
//   - CMD_*        : CPU opcodes accepted on the command register
//   - STAT_*       : bit positions inside the CPU-visible status word
//   - err_flags_t  : sticky error flags reported in status
//   - blk_addr()   : address of block idx relative to a base (32-bit wrap)
// -----------------------------------------------------------------------------
package rsa_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RX        = 4'd1,
    ST_RX_WAIT   = 4'd2,
    ST_COMPUTE   = 4'd3,
    ST_COMP_WAIT = 4'd4,
    ST_TX        = 4'd5,
    ST_TX_WAIT   = 4'd6,
    ST_DONE      = 4'd7,
    ST_ERROR     = 4'd8
  } state_e;

  localparam logic [31:0] CMD_IDLE          = 32'd0;
  localparam logic [31:0] CMD_FULL          = 32'd1;
  localparam logic [31:0] CMD_LOAD          = 32'd2;
  localparam logic [31:0] CMD_COMPUTE_STORE = 32'd3;

  localparam int STAT_DONE      = 0;
  localparam int STAT_IDLE      = 1;
  localparam int STAT_ERROR     = 2;
  localparam int STAT_TIMEOUT   = 3;
  localparam int STAT_BAD_CMD   = 4;
  localparam int STAT_DMA_ERROR = 5;
  localparam int STAT_STATE_LSB = 8;

  typedef struct packed {
    logic dma_error;
    logic bad_cmd;
    logic timeout;
    logic error;
  } err_flags_t;

  function automatic logic [31:0] blk_addr(input logic [31:0] base,
                                           input logic [31:0] idx,
                                           input logic [31:0] bytes);
    return base + idx * bytes;
  endfunction

endpackage

// File: rtl/rsa_wait_timer.sv
// -----------------------------------------------------------------------------
// rsa_wait_timer
// Up-counter that bounds how long the sequencer waits for the DMA engine.
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   clear_i   in   synchronous clear (has priority over en_i)
//   en_i      in   count one per cycle while high
//   expired_o out  high in the cycle whose edge takes the count to all-ones
// -----------------------------------------------------------------------------
module rsa_wait_timer #(
  parameter int W = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  // One below all-ones: when the counter sits here and is enabled, the next
  // edge reaches all-ones, which is the moment the wait is abandoned.
  localparam logic [W-1:0] LAST_M1 = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = en_i && !clear_i && (count_q == LAST_M1);

endmodule

// File: rtl/rsa_dma_ctrl.sv
// -----------------------------------------------------------------------------
// rsa_dma_ctrl
// Command/DMA sequencer between the CPU register file, the DMA engine and the
// modular-arithmetic core. A CPU opcode loads N_IN operand blocks by DMA,
// runs the core, and stores N_OUT result blocks by DMA.
//
//   clk, reset           system clock, asynchronous active-high reset
//   command[31:0]        opcode: 0 idle, 1 full, 2 load, 3 compute+store
//   rx_base, tx_base     DMA source / destination base addresses
//   status[31:0]         {state code [11:8], dma_err, bad_cmd, timeout,
//                         error, idle, done}
//   leds[3:0]            {error, done, busy, idle}
//   dma_rx_*             read channel: address, start pulse, data in
//   dma_tx_*             write channel: address, start pulse, data out
//   dma_done/idle/error  DMA engine status
//   eng_start/eng_done   core handshake
//   eng_operands         operand k at [k*DATA_W +: DATA_W]
//   eng_result           result k at [k*DATA_W +: DATA_W]
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | accept an opcode, idx = 0
// RX          | wait for dma_idle, then pulse dma_rx_start
// RX_WAIT     | wait for dma_done, capture operand[idx], timeout armed
// COMPUTE     | pulse eng_start
// COMP_WAIT   | wait for eng_done, capture results (no timeout)
// TX          | wait for dma_idle, then pulse dma_tx_start
// TX_WAIT     | wait for dma_done, timeout armed
// DONE        | operation complete, hold until command = 0
// ERROR       | sticky error flags shown, hold until command = 0
// -----------------------------------------------------------------------------
module rsa_dma_ctrl
  import rsa_ctrl_pkg::*;
#(
  parameter int DATA_W    = 1024,
  parameter int N_IN      = 3,
  parameter int N_OUT     = 1,
  parameter int TIMEOUT_W = 20
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             command,
  input  logic [31:0]             rx_base,
  input  logic [31:0]             tx_base,
  output logic [31:0]             status,
  output logic [3:0]              leds,
  input  logic [DATA_W-1:0]       dma_rx_data,
  output logic [31:0]             dma_rx_address,
  output logic                    dma_rx_start,
  output logic [DATA_W-1:0]       dma_tx_data,
  output logic [31:0]             dma_tx_address,
  output logic                    dma_tx_start,
  input  logic                    dma_done,
  input  logic                    dma_idle,
  input  logic                    dma_error,
  output logic                    eng_start,
  input  logic                    eng_done,
  output logic [N_IN*DATA_W-1:0]  eng_operands,
  input  logic [N_OUT*DATA_W-1:0] eng_result
);

  localparam int N_MAX     = (N_IN > N_OUT) ? N_IN : N_OUT;
  localparam int IDX_W     = (N_MAX > 1) ? $clog2(N_MAX) : 1;
  localparam int BLK_BYTES = DATA_W / 8;

  state_e            state_q, state_d;
  logic [31:0]       cmd_q, cmd_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  err_flags_t        flags_q, flags_d;
  logic              rx_start_q, rx_start_d;
  logic              tx_start_q, tx_start_d;
  logic              eng_start_q, eng_start_d;
  logic              rx_cap, res_cap;

  logic [DATA_W-1:0] operand_q [N_IN];
  logic [DATA_W-1:0] result_q  [N_OUT];

  logic cmd_bad;
  logic rx_last, tx_last;
  logic in_wait;
  logic tmo_expired;

  assign cmd_bad = (command != CMD_IDLE) && (command != CMD_FULL) &&
                   (command != CMD_LOAD) && (command != CMD_COMPUTE_STORE);
  assign rx_last = (idx_q == IDX_W'(N_IN - 1));
  assign tx_last = (idx_q == IDX_W'(N_OUT - 1));
  assign in_wait = (state_q == ST_RX_WAIT) || (state_q == ST_TX_WAIT);

  // Held clear in every non-wait state, so each wait starts from zero even
  // when RX_WAIT -> RX -> RX_WAIT loops over several blocks.
  rsa_wait_timer #(
    .W (TIMEOUT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (!in_wait),
    .en_i      (in_wait),
    .expired_o (tmo_expired)
  );

  // State register and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= CMD_IDLE;
      idx_q       <= '0;
      flags_q     <= '0;
      rx_start_q  <= 1'b0;
      tx_start_q  <= 1'b0;
      eng_start_q <= 1'b0;
      for (int k = 0; k < N_IN; k++) begin
        operand_q[k] <= '0;
      end
      for (int k = 0; k < N_OUT; k++) begin
        result_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      idx_q       <= idx_d;
      flags_q     <= flags_d;
      rx_start_q  <= rx_start_d;
      tx_start_q  <= tx_start_d;
      eng_start_q <= eng_start_d;
      for (int k = 0; k < N_IN; k++) begin
        if (rx_cap && (idx_q == IDX_W'(k))) begin
          operand_q[k] <= dma_rx_data;
        end
      end
      for (int k = 0; k < N_OUT; k++) begin
        if (res_cap) begin
          result_q[k] <= eng_result[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if ((command == CMD_FULL) || (command == CMD_LOAD)) begin
          state_d = ST_RX;
        end else if (command == CMD_COMPUTE_STORE) begin
          state_d = ST_COMPUTE;
        end else if (cmd_bad) begin
          state_d = ST_ERROR;
        end
      end
      ST_RX: begin
        if (dma_idle) state_d = ST_RX_WAIT;
      end
      ST_RX_WAIT: begin
        if (dma_error) begin
          state_d = ST_ERROR;
        end else if (dma_done) begin
          if (rx_last) begin
            state_d = (cmd_q == CMD_LOAD) ? ST_DONE : ST_COMPUTE;
          end else begin
            state_d = ST_RX;
          end
        end else if (tmo_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_COMPUTE: begin
        state_d = ST_COMP_WAIT;
      end
      ST_COMP_WAIT: begin
        if (eng_done) state_d = ST_TX;
      end
      ST_TX: begin
        if (dma_idle) state_d = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (dma_error) begin
          state_d = ST_ERROR;
        end else if (dma_done) begin
          state_d = tx_last ? ST_DONE : ST_TX;
        end else if (tmo_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (command == CMD_IDLE) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output / datapath control logic
  always_comb begin
    cmd_d       = cmd_q;
    idx_d       = idx_q;
    flags_d     = flags_q;
    rx_start_d  = 1'b0;
    tx_start_d  = 1'b0;
    eng_start_d = 1'b0;
    rx_cap      = 1'b0;
    res_cap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_d = command;
        idx_d = '0;
        if (cmd_bad) begin
          flags_d.error   = 1'b1;
          flags_d.bad_cmd = 1'b1;
        end
      end
      ST_RX: begin
        rx_start_d = dma_idle;
      end
      ST_RX_WAIT: begin
        // dma_error wins over a coincident dma_done: nothing is captured.
        if (dma_error) begin
          flags_d.error     = 1'b1;
          flags_d.dma_error = 1'b1;
        end else if (dma_done) begin
          rx_cap = 1'b1;
          idx_d  = rx_last ? '0 : idx_q + 1'b1;
        end else if (tmo_expired) begin
          flags_d.error   = 1'b1;
          flags_d.timeout = 1'b1;
        end
      end
      ST_COMPUTE: begin
        eng_start_d = 1'b1;
      end
      ST_COMP_WAIT: begin
        if (eng_done) begin
          res_cap = 1'b1;
          idx_d   = '0;
        end
      end
      ST_TX: begin
        tx_start_d = dma_idle;
      end
      ST_TX_WAIT: begin
        if (dma_error) begin
          flags_d.error     = 1'b1;
          flags_d.dma_error = 1'b1;
        end else if (dma_done) begin
          idx_d = tx_last ? '0 : idx_q + 1'b1;
        end else if (tmo_expired) begin
          flags_d.error   = 1'b1;
          flags_d.timeout = 1'b1;
        end
      end
      ST_ERROR: begin
        if (command == CMD_IDLE) flags_d = '0;
      end
      default: begin
      end
    endcase
  end

  // Decoded outputs
  logic st_idle, st_done, st_busy;

  assign st_idle = (state_q == ST_IDLE);
  assign st_done = (state_q == ST_DONE);
  assign st_busy = !st_idle && !st_done && (state_q != ST_ERROR);

  always_comb begin
    status                 = '0;
    status[STAT_DONE]      = st_done;
    status[STAT_IDLE]      = st_idle;
    status[STAT_ERROR]     = flags_q.error;
    status[STAT_TIMEOUT]   = flags_q.timeout;
    status[STAT_BAD_CMD]   = flags_q.bad_cmd;
    status[STAT_DMA_ERROR] = flags_q.dma_error;
    status[STAT_STATE_LSB +: 4] = state_q;
  end

  assign leds = {flags_q.error, st_done, st_busy, st_idle};

  assign dma_rx_address = blk_addr(rx_base, 32'(idx_q), 32'(BLK_BYTES));
  assign dma_tx_address = blk_addr(tx_base, 32'(idx_q), 32'(BLK_BYTES));

  // idx can exceed N_OUT-1 outside the TX states, so select explicitly.
  always_comb begin
    dma_tx_data = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (idx_q == IDX_W'(k)) dma_tx_data = result_q[k];
    end
  end

  assign dma_rx_start = rx_start_q;
  assign dma_tx_start = tx_start_q;
  assign eng_start    = eng_start_q;

  for (genvar k = 0; k < N_IN; k++) begin : g_ops
    assign eng_operands[k*DATA_W +: DATA_W] = operand_q[k];
  end

endmodule
